screen_spi_tx: RTL and testbench

Byte serializer for the static-screen display link. It consumes the divided serial clock `sck_in` produced by the screen's clock divider and accepts bytes from the screen controller over a valid/ready handshake. It drives the panel's SPI-style pins `lcd_sck`, `lcd_mosi`, `lcd_dc` and `lcd_cs_n` in mode 0, MSB first, with a chip-select gap between transactions. Everything runs in the `clk_fpga` domain; `sck_in` is treated as a synchronous level and edge-detected.

---
 rtl/screen_spi_tx.sv | 172 +++++++++++++++++
 tb/tb_screen_spi_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_spi_tx.sv
`default_nettype none
// ============================================================================
// Module      : screen_spi_tx
// Description : Byte serializer for the static-screen display link. Consumes
//               the divided clock sck_in as a synchronous level, accepts bytes
//               over valid/ready, and drives the panel pins in SPI mode 0,
//               MSB first, with a chip-select gap after the last byte.
// Revision    : 1.0 - initial release
// ============================================================================
module screen_spi_tx #(
  parameter int GAP_SCK = 2
) (
  input  logic       clk_fpga,
  input  logic       rst_n,
  input  logic       sck_in,
  input  logic [7:0] tx_data,
  input  logic       tx_dc,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       lcd_sck,
  output logic       lcd_mosi,
  output logic       lcd_dc,
  output logic       lcd_cs_n
);

  // Gap counter only has to reach GAP_SCK-1; keep at least one bit so the
  // counter stays legal when the gap is disabled.
  localparam int              c_GW       = (GAP_SCK > 1) ? $clog2(GAP_SCK) : 1;
  localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((GAP_SCK > 0) ? (GAP_SCK - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_SHIFT = 3'd2,
    S_NEXT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t          r_state;
  logic            r_sck_d;
  logic [7:0]      r_shreg;
  logic            r_dc;
  logic            r_last;
  logic [2:0]      r_bitcnt;
  logic [c_GW-1:0] r_gapcnt;
  logic            r_lcd_sck;
  logic            r_lcd_mosi;
  logic            r_lcd_dc;
  logic            r_lcd_cs_n;

  logic w_rise;
  logic w_fall;
  logic w_accept;

  assign w_rise   = sck_in & ~r_sck_d;
  assign w_fall   = ~sck_in & r_sck_d;
  assign tx_ready = (r_state == S_IDLE) || (r_state == S_NEXT);
  assign busy     = (r_state != S_IDLE);
  assign w_accept = tx_valid & tx_ready;

  assign lcd_sck  = r_lcd_sck;
  assign lcd_mosi = r_lcd_mosi;
  assign lcd_dc   = r_lcd_dc;
  assign lcd_cs_n = r_lcd_cs_n;

  // Delayed copy of the divided clock for edge detection.
  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_d <= 1'b0;
    end else begin
      r_sck_d <= sck_in;
    end
  end

  // Transaction FSM: handshake, bit alignment, shifting and chip-select gap.
  always_ff @(posedge clk_fpga or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shreg    <= 8'h00;
      r_dc       <= 1'b0;
      r_last     <= 1'b0;
      r_bitcnt   <= 3'd0;
      r_gapcnt   <= '0;
      r_lcd_sck  <= 1'b0;
      r_lcd_mosi <= 1'b0;
      r_lcd_dc   <= 1'b0;
      r_lcd_cs_n <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_lcd_cs_n <= 1'b1;
          r_lcd_sck  <= 1'b0;
          if (w_accept) begin
            r_shreg    <= tx_data;
            r_dc       <= tx_dc;
            r_last     <= tx_last;
            r_lcd_cs_n <= 1'b0;
            r_state    <= S_ALIGN;
          end
        end

        // Wait for a full sck_in fall so the first lcd_sck pulse is never short.
        S_ALIGN: begin
          r_lcd_cs_n <= 1'b0;
          r_lcd_sck  <= 1'b0;
          if (w_fall) begin
            r_lcd_mosi <= r_shreg[7];
            r_lcd_dc   <= r_dc;
            r_bitcnt   <= 3'd0;
            r_state    <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (w_rise) begin
            r_lcd_sck <= 1'b1;
          end
          if (w_fall) begin
            r_lcd_sck <= 1'b0;
            if (r_bitcnt == 3'd7) begin
              if (r_last) begin
                r_lcd_cs_n <= 1'b1;
                r_gapcnt   <= '0;
                r_state    <= (GAP_SCK == 0) ? S_IDLE : S_GAP;
              end else begin
                r_state <= S_NEXT;
              end
            end else begin
              r_shreg    <= {r_shreg[6:0], 1'b0};
              r_bitcnt   <= r_bitcnt + 3'd1;
              r_lcd_mosi <= r_shreg[6];
            end
          end
        end

        // Chip select held low; a fall coinciding with accept is left for ALIGN.
        S_NEXT: begin
          r_lcd_cs_n <= 1'b0;
          r_lcd_sck  <= 1'b0;
          if (w_accept) begin
            r_shreg <= tx_data;
            r_dc    <= tx_dc;
            r_last  <= tx_last;
            r_state <= S_ALIGN;
          end
        end

        S_GAP: begin
          r_lcd_cs_n <= 1'b1;
          r_lcd_sck  <= 1'b0;
          if (w_fall) begin
            if (r_gapcnt == c_GAP_LAST) begin
              r_state <= S_IDLE;
            end else begin
              r_gapcnt <= r_gapcnt + 1'b1;
            end
          end
        end

        default: begin
          r_lcd_cs_n <= 1'b1;
          r_lcd_sck  <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_screen_spi_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_screen_spi_tx
// Description : Directed self-checking bench for screen_spi_tx with an
//               8-clock sck_in divider and a pin-level byte decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_spi_tx;

  logic       clk_fpga = 1'b0;
  logic       rst_n    = 1'b0;
  logic [2:0] div      = 3'd0;
  logic       sck_in;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_dc    = 1'b0;
  logic       tx_last  = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       busy;
  logic       lcd_sck;
  logic       lcd_mosi;
  logic       lcd_dc;
  logic       lcd_cs_n;

  int n_cmp = 0;
  int n_err = 0;

  screen_spi_tx #(.GAP_SCK(2)) dut (
    .clk_fpga (clk_fpga),
    .rst_n    (rst_n),
    .sck_in   (sck_in),
    .tx_data  (tx_data),
    .tx_dc    (tx_dc),
    .tx_last  (tx_last),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .lcd_sck  (lcd_sck),
    .lcd_mosi (lcd_mosi),
    .lcd_dc   (lcd_dc),
    .lcd_cs_n (lcd_cs_n)
  );

  // 10-unit system clock; sck_in is an 8-clock divider (P = 8).
  always #5 clk_fpga = ~clk_fpga;
  always @(negedge clk_fpga) div <= div + 3'd1;
  assign sck_in = div[2];

  // Pin-level decoder: bits sampled at lcd_sck rises, bytes pushed to a queue.
  logic       prev_sck = 1'b0;
  logic       prev_cs  = 1'b1;
  logic [7:0] sh       = 8'h00;
  logic       cur_dc   = 1'b0;
  int         nb = 0, rise_cnt = 0, cs_rise_cnt = 0, bad_cs = 0;
  int         hi_run = 0, lo_run = 0, min_high = 1000, min_low = 1000;
  logic [7:0] got_b[$];
  logic       got_dc[$];

  always @(negedge clk_fpga) begin
    if (!rst_n) begin
      prev_sck = 1'b0;
      prev_cs  = 1'b1;
      nb       = 0;
      hi_run   = 0;
      lo_run   = 0;
    end else begin
      if (lcd_sck && !prev_sck) begin
        rise_cnt++;
        if (lcd_cs_n) bad_cs++;
        if (nb != 0 && lo_run < min_low) min_low = lo_run;
        lo_run = 0;
        if (nb == 0) cur_dc = lcd_dc;
        sh = {sh[6:0], lcd_mosi};
        nb++;
        if (nb == 8) begin
          got_b.push_back(sh);
          got_dc.push_back(cur_dc);
          nb = 0;
        end
      end
      if (lcd_sck) hi_run++;
      else begin
        if (prev_sck && hi_run < min_high) min_high = hi_run;
        hi_run = 0;
        if (nb != 0) lo_run++;
      end
      if (lcd_cs_n && !prev_cs) cs_rise_cnt++;
      prev_sck = lcd_sck;
      prev_cs  = lcd_cs_n;
    end
  end

  task automatic step();
    @(negedge clk_fpga);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int val, input int lo, input int hi);
    n_cmp++;
    assert (val >= lo && val <= hi) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic wait_ready(input int bound);
    int n = 0;
    while (!tx_ready && n < bound) begin step(); n++; end
    if (!tx_ready) check("timeout_ready", {31'd0, tx_ready}, 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin step(); n++; end
    if (busy) check("timeout_idle", {31'd0, busy}, 32'd0);
  endtask

  // Offer a byte and hold valid through the accepting edge.
  task automatic send_hold(input logic [7:0] d, input logic dc, input logic last);
    tx_data  = d;
    tx_dc    = dc;
    tx_last  = last;
    tx_valid = 1'b1;
    wait_ready(300);
    step();
  endtask

  task automatic check_byte(input string tag, input logic [7:0] eb, input logic edc);
    check({tag, "_avail"}, {31'd0, (got_b.size() > 0)}, 32'd1);
    if (got_b.size() > 0) begin
      check({tag, "_data"}, {24'd0, got_b.pop_front()}, {24'd0, eb});
      check({tag, "_dc"}, {31'd0, got_dc.pop_front()}, {31'd0, edc});
    end
  endtask

  int r0, cr0, n, ready_lo;
  logic stall_bad_cs, stall_bad_sck, stall_bad_rdy, stall_bad_busy;

  initial begin
    // Reset state
    step(); step();
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_cs_n",     {31'd0, lcd_cs_n}, 32'd1);
    check("rst_sck",      {31'd0, lcd_sck},  32'd0);
    check("rst_mosi",     {31'd0, lcd_mosi}, 32'd0);
    check("rst_dc",       {31'd0, lcd_dc},   32'd0);
    rst_n = 1'b1;
    step(); step();

    // Single byte 0xA5, dc=1, last=1
    r0 = rise_cnt;
    send_hold(8'hA5, 1'b1, 1'b1);
    tx_valid = 1'b0;
    check("single_cs_low", {31'd0, lcd_cs_n}, 32'd0);
    n = 0;
    while (!lcd_cs_n && n < 200) begin step(); n++; end
    check("single_cs_rise", {31'd0, lcd_cs_n}, 32'd1);
    n = 0;
    while (!tx_ready && n < 100) begin step(); n++; end
    check_rng("single_cs_high_time", n, 16, 17);
    check("single_rises", rise_cnt - r0, 32'd8);
    check_byte("single", 8'hA5, 1'b1);
    check("single_lcd_dc", {31'd0, lcd_dc}, 32'd1);

    // Burst of three bytes with valid held
    cr0 = cs_rise_cnt;
    send_hold(8'h2C, 1'b0, 1'b0);
    send_hold(8'hFF, 1'b1, 1'b0);
    send_hold(8'h00, 1'b1, 1'b1);
    tx_valid = 1'b0;
    wait_idle(400);
    check("burst_cs_rises", cs_rise_cnt - cr0, 32'd1);
    check_byte("burst0", 8'h2C, 1'b0);
    check_byte("burst1", 8'hFF, 1'b1);
    check_byte("burst2", 8'h00, 1'b1);

    // Handshake hold: valid stays high with changing data while not ready
    send_hold(8'h96, 1'b1, 1'b0);
    ready_lo = 0;
    while (!tx_ready && ready_lo < 200) begin
      tx_data = tx_data + 8'h11;
      tx_last = ~tx_last;
      step();
      ready_lo++;
    end
    check_rng("hold_ready_low_cycles", ready_lo, 64, 73);
    tx_data = 8'h3C;
    tx_dc   = 1'b0;
    tx_last = 1'b0;
    step();
    tx_valid = 1'b0;

    // Stall in NEXT for 100 cycles
    n = 0;
    while (!(tx_ready && busy) && n < 200) begin step(); n++; end
    stall_bad_cs = 0; stall_bad_sck = 0; stall_bad_rdy = 0; stall_bad_busy = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (lcd_cs_n)  stall_bad_cs   = 1'b1;
      if (lcd_sck)   stall_bad_sck  = 1'b1;
      if (!tx_ready) stall_bad_rdy  = 1'b1;
      if (!busy)     stall_bad_busy = 1'b1;
    end
    check("stall_cs_n_low",  {31'd0, stall_bad_cs},   32'd0);
    check("stall_sck_low",   {31'd0, stall_bad_sck},  32'd0);
    check("stall_ready",     {31'd0, stall_bad_rdy},  32'd0);
    check("stall_busy",      {31'd0, stall_bad_busy}, 32'd0);
    check("stall_lcd_dc",    {31'd0, lcd_dc},         32'd0);
    check_byte("hold0", 8'h96, 1'b1);
    check_byte("hold1", 8'h3C, 1'b0);

    // Mid-byte reset after 3 bits of 0x81
    send_hold(8'h81, 1'b1, 1'b1);
    tx_valid = 1'b0;
    r0 = rise_cnt;
    n = 0;
    while (rise_cnt < r0 + 3 && n < 200) begin step(); n++; end
    check("mrst_pre_sck", {31'd0, lcd_sck}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_cs_n",  {31'd0, lcd_cs_n}, 32'd1);
    check("mrst_sck",   {31'd0, lcd_sck},  32'd0);
    check("mrst_mosi",  {31'd0, lcd_mosi}, 32'd0);
    check("mrst_ready", {31'd0, tx_ready}, 32'd1);
    check("mrst_busy",  {31'd0, busy},     32'd0);
    step(); step(); step();
    rst_n = 1'b1;
    r0 = rise_cnt;
    for (int i = 0; i < 60; i++) step();
    check("mrst_no_pulses",  rise_cnt - r0, 32'd0);
    check("mrst_post_ready", {31'd0, tx_ready}, 32'd1);
    check("mrst_post_cs_n",  {31'd0, lcd_cs_n}, 32'd1);
    check("mrst_no_byte",    got_b.size(), 32'd0);

    // Alignment corner: accept on the very cycle a sck_in fall is registered
    n = 0;
    while (div != 3'd0 && n < 16) begin step(); n++; end
    tx_data  = 8'hB4;
    tx_dc    = 1'b0;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    n = 0;
    while (!lcd_sck && n < 40) begin step(); n++; end
    check("align_first_rise", n, 32'd12);
    wait_idle(300);
    check_byte("align", 8'hB4, 1'b0);
    check("min_sck_high", min_high, 32'd4);
    check("min_sck_low",  min_low,  32'd4);
    check("no_pulse_cs_high", bad_cs, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop if anything above stalls unexpectedly.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
